riscv_multicycle_core: RTL
==========================

RISCV_MULTICYCLE_CORE -- requirements
Module: riscv_multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of architectural registers; legal values are 16 (RV32E) and 32.
REQ-003 SHALL have parameter UART_REG_IDX, default 10, index of the register whose low byte drives uart_reg.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- cpu_clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, equal to the PC.
- imem_valid  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word address, bits [1:0] forced to 0.
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  access complete; dmem_rdata is valid on loads.
- dmem_rdata  in  32  load data.
- uart_reg  out  8  low byte of register UART_REG_IDX.
- uart_wr  out  1  one-cycle pulse when register UART_REG_IDX is written.
- ALU_OUT_check  out  32  registered ALU result, for debug.
- halted  out  1  core is in HALT.

Function
REQ-005 SHALL execute RV32I LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, all OP-IMM and all OP instructions; any other opcode SHALL retire as a NOP (PC+4, no register or memory write).
REQ-006 SHALL sequence each instruction through the states FETCH -> DECODE -> EXEC -> (MEM, for LW/SW only) -> WB -> FETCH.
REQ-007 In FETCH, imem_req SHALL be held high until imem_valid is sampled high; the instruction SHALL then be latched and the FSM SHALL move to DECODE.
REQ-008 In MEM, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be held stable until dmem_ready is sampled high; request signals SHALL be low in every other state.
REQ-009 Cycle counts, with imem_valid and dmem_ready high on the first request cycle, SHALL be: non-memory instruction 4 cycles; LW/SW 5 cycles.
REQ-010 The register file SHALL be written only in WB; writes to x0 SHALL be dropped; x0 SHALL read 0.
REQ-011 When REG_COUNT=16, reads of x16..x31 SHALL return 0 and writes to x16..x31 SHALL be dropped.
REQ-012 PC update SHALL occur only in WB, as follows:
- taken branch / JAL: PC+imm.
- JALR: (rs1+imm) with bit 0 cleared.
- otherwise: PC+4.
- all PC arithmetic is modulo 2^32, and 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-013 JAL/JALR SHALL write PC+4 (old PC) to rd.
REQ-014 LW/SW SHALL perform word accesses regardless of funct3.
REQ-015 SRA/SRAI SHALL sign-extend; shift amounts SHALL use bits [4:0] only.
REQ-016 uart_wr SHALL pulse in the WB cycle that writes rd==UART_REG_IDX with rd!=0; uart_reg SHALL update the following cycle.
REQ-017 ALU_OUT_check SHALL be registered at the end of EXEC and hold its value until the next EXEC.

Reset
REQ-018 On reset, the core SHALL enter FETCH with PC=RESET_PC, and SHALL drive imem_req=0 for that reset cycle.
REQ-019 On reset, dmem_req, dmem_we, uart_wr and halted SHALL be 0, and ALU_OUT_check SHALL be 0.
REQ-020 On reset, all registers SHALL be cleared to 0, so uart_reg=0.
REQ-021 Reset asserted in any state, including mid-handshake, SHALL abort the instruction with no register write and request signals low the next cycle.

Configuration
REQ-022 Macro RVMC_EBREAK_HALT_EN SHALL select the EBREAK behaviour:
- defined: EBREAK (32'h0010_0073) enters HALT in WB without changing PC; halted=1 and no further requests are issued until reset.
- undefined: EBREAK retires as a NOP and halted is tied to 0.

Verification
REQ-023 Reset, then imem_valid delayed 3 cycles -> imem_addr=RESET_PC and imem_req held high for 4 cycles.
REQ-024 ADDI x10,x0,0x41 -> uart_wr pulses once and uart_reg=8'h41; ALU instruction completes in 4 cycles.
REQ-025 SW x5,8(x0) with x5=32'hDEAD_BEEF, dmem_ready delayed 2 cycles, then LW x6,8(x0) -> dmem_addr=8, dmem_wdata=DEADBEEF, and x6=DEADBEEF.
REQ-026 BLT x1,x2,-8 with x1=-1, x2=1 -> taken; BLTU with the same operands -> not taken, PC+4.
REQ-027 JALR x1,x2,3 with x2=0x100 and PC=0x20 -> PC=0x102 and x1=0x24.
REQ-028 EBREAK with RVMC_EBREAK_HALT_EN defined -> halted=1 and imem_req stays 0 for 20 cycles; reset clears halted.

Source files
------------

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
//   Multicycle RV32I subset core (RV32E when REG_COUNT=16). Each instruction
//   walks FETCH -> DECODE -> EXEC -> (MEM for loads/stores) -> WB -> FETCH.
//   Unsupported opcodes retire as NOPs.
//
// Parameters
//   RESET_PC      PC loaded on reset
//   REG_COUNT     architectural registers, 16 or 32
//   UART_REG_IDX  register whose low byte is mirrored on uart_reg
//
// Ports
//   cpu_clk, reset                  clock, synchronous active-high reset
//   imem_req/addr/valid/rdata       instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/ready/rdata  word-wide data handshake
//   uart_reg, uart_wr               low byte of UART_REG_IDX, write pulse in WB
//   ALU_OUT_check                   EXEC result captured at end of EXEC
//   halted                          core parked in HALT
//
// Configuration
//   RVMC_EBREAK_HALT_EN  when defined, EBREAK parks the core in HALT until
//                        reset; otherwise EBREAK is a NOP and halted is 0.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          REG_COUNT    = 32,
  parameter int          UART_REG_IDX = 10
) (
  input  logic        cpu_clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [7:0]  uart_reg,
  output logic        uart_wr,
  output logic [31:0] ALU_OUT_check,
  output logic        halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [4:0] UART_IDX   = 5'(UART_REG_IDX);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_q, alu_d, npc_q, npc_d, ld_q, ld_d;
  // Always 32 entries; entries at or above REG_COUNT are never written and
  // therefore read as 0.
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_dec, op_b, alu_res, exec_res, npc_calc, wb_data;
  logic [4:0]  shamt;
  logic        is_mem, is_store, writes_rd, wr_en, br_taken;
  logic        imem_req_c, dmem_req_c, uart_wr_c;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign f3       = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = (opcode == OPC_LOAD) || is_store;
  assign writes_rd = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                     (opcode == OPC_JALR) || (opcode == OPC_LOAD) || (opcode == OPC_OP_IMM) ||
                     (opcode == OPC_OP);
  assign wr_en    = writes_rd && (rd != 5'd0) && (32'(rd) < 32'(REG_COUNT));
  assign wb_data  = (opcode == OPC_LOAD) ? ld_q : alu_q;

  always_comb begin
    imm_dec = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
      OPC_STORE:  imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH: imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
      OPC_JAL:    imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:    imm_dec = '0;
    endcase
  end

  // ALU: register operand for OP, immediate for OP-IMM. SUB exists only in OP;
  // SRA/SRAI share ir[30] as selector.
  assign op_b  = (opcode == OPC_OP) ? b_q : imm_q;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (f3)
      3'd0: alu_res = (opcode == OPC_OP && ir_q[30]) ? a_q - op_b : a_q + op_b;
      3'd1: alu_res = a_q << shamt;
      3'd2: alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
      3'd3: alu_res = {31'b0, a_q < op_b};
      3'd4: alu_res = a_q ^ op_b;
      3'd5: alu_res = ir_q[30] ? 32'($signed(a_q) >>> shamt) : a_q >> shamt;
      3'd6: alu_res = a_q | op_b;
      default: alu_res = a_q & op_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'd0: br_taken = (a_q == b_q);
      3'd1: br_taken = (a_q != b_q);
      3'd4: br_taken = ($signed(a_q) <  $signed(b_q));
      3'd5: br_taken = ($signed(a_q) >= $signed(b_q));
      3'd6: br_taken = (a_q <  b_q);
      3'd7: br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase
  end

  // EXEC result doubles as the rd value (JAL/JALR link) and the memory address.
  always_comb begin
    exec_res = '0;
    npc_calc = pc_q + 32'd4;
    case (opcode)
      OPC_LUI:             exec_res = imm_q;
      OPC_AUIPC:           exec_res = pc_q + imm_q;
      OPC_JAL: begin
        exec_res = pc_q + 32'd4;
        npc_calc = pc_q + imm_q;
      end
      OPC_JALR: begin
        exec_res = pc_q + 32'd4;
        npc_calc = (a_q + imm_q) & 32'hFFFF_FFFE;
      end
      OPC_BRANCH:          if (br_taken) npc_calc = pc_q + imm_q;
      OPC_LOAD, OPC_STORE: exec_res = a_q + imm_q;
      OPC_OP, OPC_OP_IMM:  exec_res = alu_res;
      default:             exec_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    npc_d   = npc_q;
    ld_d    = ld_q;
    rf_d    = rf_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    uart_wr_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs1];
        b_d     = rf_q[rs2];
        imm_d   = imm_dec;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d   = exec_res;
        npc_d   = npc_calc;
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ready) begin
          if (!is_store) ld_d = dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (wr_en) begin
          rf_d[rd]  = wb_data;
          uart_wr_c = (rd == UART_IDX);
        end
`ifdef RVMC_EBREAK_HALT_EN
        if (ir_q == 32'h0010_0073) begin
          state_d = S_HALT;
        end else begin
          pc_d    = npc_q;
          state_d = S_FETCH;
        end
`else
        pc_d    = npc_q;
        state_d = S_FETCH;
`endif
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      npc_q   <= '0;
      ld_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      npc_q   <= npc_d;
      ld_q    <= ld_d;
      rf_q    <= rf_d;
    end
  end

  // Requests are masked while reset is asserted so an aborted handshake drops
  // immediately, whatever state the FSM was in.
  assign imem_req      = imem_req_c & ~reset;
  assign imem_addr     = pc_q;
  assign dmem_req      = dmem_req_c & ~reset;
  assign dmem_we       = dmem_req & is_store;
  assign dmem_addr     = dmem_req ? {alu_q[31:2], 2'b00} : 32'h0;
  assign dmem_wdata    = dmem_req ? b_q : 32'h0;
  assign uart_wr       = uart_wr_c & ~reset;
  assign uart_reg      = rf_q[UART_IDX][7:0];
  assign ALU_OUT_check = alu_q;
`ifdef RVMC_EBREAK_HALT_EN
  assign halted        = (state_q == S_HALT) & ~reset;
`else
  assign halted        = 1'b0;
`endif

endmodule
